// File: rtl/pong_engine.sv
// Frame-rate pong gameplay engine: paddles, 2-D ball, wall/paddle bounce, scoring, serve and game-over.
// Optional feature macro PONG_SPIN_EN: a moving paddle sets the ball's vertical direction on a hit.
module pong_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 50,
    parameter int BALL_SIZE   = 8,
    parameter int P1_X        = 40,
    parameter int P2_X        = 600,
    parameter int P_STEP      = 4,
    parameter int B_SPD_X     = 4,
    parameter int B_SPD_Y     = 2,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 9,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               p1_up,
    input  logic               p1_dn,
    input  logic               p1_srv,
    input  logic               p2_up,
    input  logic               p2_dn,
    input  logic               p2_srv,
    output logic [8:0]         p1_y,
    output logic [8:0]         p2_y,
    output logic [9:0]         ball_x,
    output logic [8:0]         ball_y,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         state,
    output logic               server,
    output logic               point
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    // Geometry in 11-bit signed so that subtraction near zero never wraps.
    localparam logic signed [10:0] PY_MAX_S = 11'(SCREEN_H - PADDLE_H);
    localparam logic signed [10:0] STEP_S   = 11'(P_STEP);
    localparam logic signed [10:0] BSX_S    = 11'(B_SPD_X);
    localparam logic signed [10:0] BSY_S    = 11'(B_SPD_Y);
    localparam logic signed [10:0] BY_MAX_S = 11'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] BX_MAX_S = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] HIT_L_S  = 11'(P1_X + PADDLE_W);
    localparam logic signed [10:0] HIT_R_S  = 11'(P2_X - BALL_SIZE);
    localparam logic signed [10:0] PH_S     = 11'(PADDLE_H);
    localparam logic signed [10:0] BS_S     = 11'(BALL_SIZE);

    localparam logic [8:0]         PY_RST    = 9'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [8:0]         BALL_OFS  = 9'((PADDLE_H - BALL_SIZE) / 2);
    localparam logic [9:0]         BX_L      = 10'(P1_X + PADDLE_W);
    localparam logic [9:0]         BX_R      = 10'(P2_X - BALL_SIZE);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_POINT = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    function automatic logic signed [10:0] ext9(input logic [8:0] v);
        return $signed({2'b00, v});
    endfunction

    function automatic logic [8:0] paddle_next(input logic [8:0] y, input logic up, input logic dn);
        logic signed [10:0] t;
        t = ext9(y);
        if (up && !dn) begin
            t = t - STEP_S;
        end else if (dn && !up) begin
            t = t + STEP_S;
        end else begin
            t = ext9(y);
        end
        if (t < 11'sd0) begin
            return 9'd0;
        end else if (t > PY_MAX_S) begin
            return PY_MAX_S[8:0];
        end else begin
            return t[8:0];
        end
    endfunction

    function automatic logic overlap(input logic [8:0] by, input logic [8:0] py);
        return ((ext9(by) + BS_S) > ext9(py)) && (ext9(by) < (ext9(py) + PH_S));
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s < WIN) ? (s + SCORE_W'(1)) : s;
    endfunction

    state_t              state_q, state_d;
    logic [8:0]          p1_q, p1_d, p2_q, p2_d;
    logic [9:0]          bx_q, bx_d;
    logic [8:0]          by_q, by_d;
    logic                dx_q, dx_d;   // 1 = moving right
    logic                dy_q, dy_d;   // 1 = moving down
    logic [SCORE_W-1:0]  s1_q, s1_d, s2_q, s2_d;
    logic                server_q, server_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                point_q, point_d;

    logic [8:0]          p1_n_s, p2_n_s;
    logic signed [10:0]  bx_s, by_s;
    logic                vdy_s;

    assign p1_n_s = paddle_next(p1_q, p1_up, p1_dn);
    assign p2_n_s = paddle_next(p2_q, p2_up, p2_dn);
    assign bx_s   = $signed({1'b0, bx_q});
    assign by_s   = ext9(by_q);

    // Next-state and next-output logic; nothing but the point pulse changes off a frame tick.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        bx_d     = bx_q;
        by_d     = by_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        server_d = server_q;
        hold_d   = hold_q;
        point_d  = 1'b0;
        vdy_s    = dy_q;
        if (frame_tick) begin
            case (state_q)
                ST_SERVE: begin
                    p1_d = p1_n_s;
                    p2_d = p2_n_s;
                    if (server_q ? p2_srv : p1_srv) begin
                        state_d = ST_PLAY;
                        dx_d    = ~server_q;
                        dy_d    = 1'b1;
                    end else begin
                        bx_d = server_q ? BX_R : BX_L;
                        by_d = (server_q ? p2_n_s : p1_n_s) + BALL_OFS;
                    end
                end
                ST_PLAY: begin
                    p1_d = p1_n_s;
                    p2_d = p2_n_s;
                    if (!dy_q) begin
                        if (by_s < BSY_S) begin
                            by_d  = 9'd0;
                            vdy_s = 1'b1;
                        end else begin
                            by_d = by_q - BSY_S[8:0];
                        end
                    end else begin
                        if ((by_s + BSY_S) > BY_MAX_S) begin
                            by_d  = BY_MAX_S[8:0];
                            vdy_s = 1'b0;
                        end else begin
                            by_d = by_q + BSY_S[8:0];
                        end
                    end
                    dy_d = vdy_s;
                    // Paddle contact uses the pre-update paddle; the wall result above still stands.
                    if (!dx_q) begin
                        if (((bx_s - BSX_S) <= HIT_L_S) && (bx_s >= HIT_L_S) && overlap(by_q, p1_q)) begin
                            bx_d = BX_L;
                            dx_d = 1'b1;
`ifdef PONG_SPIN_EN
                            dy_d = (p1_up ^ p1_dn) ? p1_dn : vdy_s;
`else
                            dy_d = vdy_s;
`endif
                        end else if (bx_s < BSX_S) begin
                            s2_d     = sat_inc(s2_q);
                            server_d = 1'b0;
                            state_d  = ST_POINT;
                            point_d  = 1'b1;
                            hold_d   = {HOLD_W{1'b0}};
                        end else begin
                            bx_d = bx_q - BSX_S[9:0];
                        end
                    end else begin
                        if (((bx_s + BSX_S) >= HIT_R_S) && (bx_s <= HIT_R_S) && overlap(by_q, p2_q)) begin
                            bx_d = BX_R;
                            dx_d = 1'b0;
`ifdef PONG_SPIN_EN
                            dy_d = (p2_up ^ p2_dn) ? p2_dn : vdy_s;
`else
                            dy_d = vdy_s;
`endif
                        end else if ((bx_s + BSX_S) > BX_MAX_S) begin
                            s1_d     = sat_inc(s1_q);
                            server_d = 1'b1;
                            state_d  = ST_POINT;
                            point_d  = 1'b1;
                            hold_d   = {HOLD_W{1'b0}};
                        end else begin
                            bx_d = bx_q + BSX_S[9:0];
                        end
                    end
                end
                ST_POINT: begin
                    p1_d = p1_n_s;
                    p2_d = p2_n_s;
                    if (hold_q == HOLD_LAST) begin
                        hold_d = {HOLD_W{1'b0}};
                        if ((s1_q == WIN) || (s2_q == WIN)) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_SERVE;
                            bx_d    = server_q ? BX_R : BX_L;
                            by_d    = (server_q ? p2_n_s : p1_n_s) + BALL_OFS;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_OVER: begin
                    if (p1_srv || p2_srv) begin
                        s1_d     = {SCORE_W{1'b0}};
                        s2_d     = {SCORE_W{1'b0}};
                        server_d = 1'b0;
                        state_d  = ST_SERVE;
                        hold_d   = {HOLD_W{1'b0}};
                        bx_d     = BX_L;
                        by_d     = p1_q + BALL_OFS;
                        dx_d     = 1'b1;
                        dy_d     = 1'b1;
                    end else begin
                        state_d = ST_OVER;
                    end
                end
                default: begin
                    state_d = ST_SERVE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SERVE;
            p1_q     <= PY_RST;
            p2_q     <= PY_RST;
            bx_q     <= BX_L;
            by_q     <= PY_RST + BALL_OFS;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            s1_q     <= {SCORE_W{1'b0}};
            s2_q     <= {SCORE_W{1'b0}};
            server_q <= 1'b0;
            hold_q   <= {HOLD_W{1'b0}};
            point_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            server_q <= server_d;
            hold_q   <= hold_d;
            point_q  <= point_d;
        end
    end

    assign p1_y     = p1_q;
    assign p2_y     = p2_q;
    assign ball_x   = bx_q;
    assign ball_y   = by_q;
    assign p1_score = s1_q;
    assign p2_score = s2_q;
    assign state    = state_q;
    assign server   = server_q;
    assign point    = point_q;

endmodule
